// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and
// parameter legality checks used by both the Tx and Rx paths.
package uart_pkg;

  // Frame state encoding (3 bits)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Serial line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // True when the frame geometry is one the UART blocks support.
  function automatic bit params_ok(input int data_w, input int cpb, input int stop_bits);
    return (data_w >= 5) && (data_w <= 9) && (cpb >= 2) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of each bit. clr holds it at 0 so every bit starts on a fresh period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running period counter; wraps on tick, held at 0 while cleared
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits. The line idles high and tx is a
// flop whose next value is chosen together with the next state.
// Optional feature macro: UART_TX_PARITY_EN (adds parity_odd and PARITY).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
`ifdef UART_TX_PARITY_EN
  ,
  input  logic              parity_odd
`endif
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if (!params_ok(DATA_W, CLKS_PER_BIT, STOP_BITS)) begin : g_bad_params
      $error("uart_tx_serializer: unsupported DATA_W/CLKS_PER_BIT/STOP_BITS");
    end
  endgenerate

  logic [2:0]        state;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic              tick;
  logic              accept;
`ifdef UART_TX_PARITY_EN
  logic              par_bit;
`endif

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  // Period counter sits at 0 in IDLE so START gets a full first bit.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (state == IDLE),
    .tick   (tick)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at accept so later input changes cannot disturb it
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)     par_bit <= 1'b0;
    else if (accept) par_bit <= (^tx_data) ^ parity_odd;
  end
`endif

  // Frame sequencer; tx is loaded with the level of the state being entered
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      tx       <= LINE_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= LINE_IDLE;
          if (accept) begin
            state   <= START;
            tx      <= START_LVL;
            shift   <= tx_data;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state    <= STOP;
              tx       <= STOP_LVL;
              stop_cnt <= 1'b0;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            tx       <= STOP_LVL;
            stop_cnt <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              state <= IDLE;
              tx    <= LINE_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer. It converts a parallel byte, accepted over a valid/ready handshake, into an asynchronous serial frame: start bit, data bits LSB-first, optional parity, then stop bit(s).
- It is the transmit counterpart of the UART Rx path. Its frames must be decodable by the Rx falling-edge start detection, so the line idles high and every frame begins with a clean 1->0 transition.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- arst_n  in  1  asynchronous active-low reset; one clock, no other reset.
- tx_data  in  DATA_W  parallel word to send; sampled only on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- tx  out  1  serial line; registered output, idles high.
- busy  out  1  frame in progress; equals NOT IDLE.
- parity_odd  in  1  present only with UART_TX_PARITY_EN: 1 selects odd parity, 0 selects even.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, tx=1, tx_ready=1, busy=0.
  - Shift register, bit counter and baud counter cleared.
- Handshake:
  - A word is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - tx_valid while busy is ignored; tx_data changes after acceptance have no effect.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1. On accept, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. The first low cycle is the cycle after the accept edge.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. Exactly DATA_W bits, LSB first.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state or bit change.
  - Bit period is exact; no drift accumulates across a frame.
- Frame length, accept to return to IDLE: (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P is 1 with parity and 0 without.
- Back-to-back frames:
  - tx_ready rises in the IDLE cycle after the final stop cycle.
  - With tx_valid held high, exactly one IDLE cycle (tx=1) separates frames. The effective stop period is therefore +1 cycle.
- Reset mid-frame: the frame aborts and tx returns to 1 immediately. A partially sent byte is not resent.
- tx is a flop, so it must never glitch.
- busy and tx_ready are decoded from state only, never from inputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds the parity_odd port and the PARITY state.
  - Parity = XOR(latched data) XOR parity_odd.
  - parity_odd is sampled at accept, together with tx_data.
- Undefined: no parity_odd port, no PARITY state, P=0.

Decomposition:
- Shared package uart_pkg holds:
  - State enum/localparams IDLE, START, DATA, PARITY, STOP, in 3-bit encoding.
  - Line-level constants LINE_IDLE=1, START_LVL=0, STOP_LVL=1.
  - Parameter legality checks, shared with the Rx side.
- One sub-module, uart_baud_tick:
  - Counter with clear input; emits a one-cycle tick at CLKS_PER_BIT-1.
  - Reusable by the Rx oversampler.

Test Plan:
1. CLKS_PER_BIT=4, send 0xA5 -> tx levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_ready low for 40 cycles; then high.
2. tx_valid held with 0x00 then 0xFF -> frames back-to-back; between the two start bits, tx high for exactly 4+1 cycles; second frame bits all 1.
3. Mid-frame, assert tx_valid with 0x3C -> ignored; the original 0x5A frame completes unchanged; 0x3C is accepted only when tx_ready=1.
4. Assert arst_n=0 during data bit 3 -> tx=1 and tx_ready=1 in the same cycle; after release, 0x81 is sent correctly.
5. UART_TX_PARITY_EN: 0x07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame is 44 cycles at CLKS_PER_BIT=4.
6. STOP_BITS=2, CLKS_PER_BIT=4 -> stop high for 8 cycles; total frame 44 cycles.
